// File: rtl/dp_mem_be.sv
// rtl/dp_mem_be.sv - true dual-port byte-enable RAM with optional output register and clear sequencer
module dp_mem_be #(
    parameter int WORD     = 32,
    parameter int ADDR     = 16,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              a_en,
    input  logic [WORD/8-1:0] a_we,
    input  logic [ADDR-1:0]   a_addr,
    input  logic [WORD-1:0]   a_wdata,
    output logic [WORD-1:0]   a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [WORD/8-1:0] b_we,
    input  logic [ADDR-1:0]   b_addr,
    input  logic [WORD-1:0]   b_wdata,
    output logic [WORD-1:0]   b_rdata,
    output logic              b_rvalid
);
    localparam int NB    = WORD / 8;
    localparam int DEPTH = 2 ** ADDR;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state;
    logic [ADDR-1:0]   r_cnt;
    logic              r_busy;
    logic [WORD-1:0]   r_mem [DEPTH];

    logic [WORD-1:0]   r_a_d1, r_a_d2, r_b_d1, r_b_d2;
    logic              r_a_v1, r_a_v2, r_b_v1, r_b_v2;

    logic              w_a_go, w_a_wr, w_b_go, w_b_wr;
    logic [WORD-1:0]   w_a_old, w_b_old, w_a_d1, w_b_d1;
    logic              w_a_v1, w_b_v1;

    function automatic logic [WORD-1:0] merge(input logic [WORD-1:0] old_w,
                                              input logic [WORD-1:0] new_w,
                                              input logic [NB-1:0]   we);
        merge = old_w;
        for (int i = 0; i < NB; i++)
            if (we[i]) merge[8*i +: 8] = new_w[8*i +: 8];
    endfunction

    assign w_a_go  = a_en & ~r_busy;
    assign w_a_wr  = w_a_go & (|a_we);
    assign w_b_go  = b_en & ~r_busy;
    assign w_b_wr  = w_b_go & (|b_we);
    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    // B is written first so that A overrides on bytes both ports enable
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++)
                if (w_b_wr && b_we[i]) r_mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
            for (int i = 0; i < NB; i++)
                if (w_a_wr && a_we[i]) r_mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        end
    end

    always_comb begin
        w_a_d1 = r_a_d1;
        w_a_v1 = 1'b0;
        if (w_a_go && !w_a_wr) begin
            w_a_d1 = w_a_old;
            w_a_v1 = 1'b1;
        end else if (w_a_wr && RDW_MODE == 0) begin
            w_a_d1 = w_a_old;
            w_a_v1 = 1'b1;
        end else if (w_a_wr && RDW_MODE == 1) begin
            w_a_d1 = merge(w_a_old, a_wdata, a_we);
            w_a_v1 = 1'b1;
        end
    end

    always_comb begin
        w_b_d1 = r_b_d1;
        w_b_v1 = 1'b0;
        if (w_b_go && !w_b_wr) begin
            w_b_d1 = w_b_old;
            w_b_v1 = 1'b1;
        end else if (w_b_wr && RDW_MODE == 0) begin
            w_b_d1 = w_b_old;
            w_b_v1 = 1'b1;
        end else if (w_b_wr && RDW_MODE == 1) begin
            w_b_d1 = merge(w_b_old, b_wdata, b_we);
            w_b_v1 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_d1 <= '0;
            r_a_v1 <= 1'b0;
            r_a_d2 <= '0;
            r_a_v2 <= 1'b0;
            r_b_d1 <= '0;
            r_b_v1 <= 1'b0;
            r_b_d2 <= '0;
            r_b_v2 <= 1'b0;
        end else begin
            r_a_d1 <= w_a_d1;
            r_a_v1 <= w_a_v1;
            r_b_d1 <= w_b_d1;
            r_b_v1 <= w_b_v1;
            if (r_a_v1) r_a_d2 <= r_a_d1;
            if (r_b_v1) r_b_d2 <= r_b_d1;
            r_a_v2 <= r_a_v1;
            r_b_v2 <= r_b_v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + ADDR'(1);
                    if (r_cnt == '1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign a_rdata  = (OUT_REG != 0) ? r_a_d2 : r_a_d1;
    assign a_rvalid = (OUT_REG != 0) ? r_a_v2 : r_a_v1;
    assign b_rdata  = (OUT_REG != 0) ? r_b_d2 : r_b_d1;
    assign b_rvalid = (OUT_REG != 0) ? r_b_v2 : r_b_v1;
endmodule
